// File: rtl/nibble_serial_sub8.sv
// Multi-cycle unsigned subtractor: diff = a - b - b_in, computed one SLICE-bit
// slice per clock through a single add slice, with a start/busy/done handshake.
module nibble_serial_sub8 #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    localparam int NPASS = WIDTH / SLICE;
    localparam int KW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NPASS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] a_k_s;
    logic [SLICE-1:0] b_k_s;
    logic [SLICE:0]   sum_s;
    logic             c_next_s;
    logic [WIDTH-1:0] part_ins_s;

    // Shared slice adder: subtraction as a + ~b + carry, carry seeded with ~b_in.
    always_comb begin
        a_k_s      = a_q[k_q*SLICE +: SLICE];
        b_k_s      = b_q[k_q*SLICE +: SLICE];
        sum_s      = {1'b0, a_k_s} + {1'b0, ~b_k_s} + {{SLICE{1'b0}}, carry_q};
        c_next_s   = sum_s[SLICE];
        part_ins_s = part_q;
        part_ins_s[k_q*SLICE +: SLICE] = sum_s[SLICE-1:0];
    end

    // Next-state and handshake logic; outputs only move on the final slice.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~b_in;
                    k_d     = {KW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                part_d  = part_ins_s;
                carry_d = c_next_s;
                if (k_q == LAST_K) begin
                    diff_d  = part_ins_s;
                    bout_d  = ~c_next_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    k_d     = {KW{1'b0}};
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + KW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= {KW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            part_q  <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign diff  = diff_q;
    assign b_out = bout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_nibble_serial_sub8.sv
// Directed bench for nibble_serial_sub8 with hand-computed expected results.
module tb_nibble_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic [7:0] diff;
    logic       b_out;
    logic       busy;
    logic       done;

    int         checks;
    int         errors;
    logic [7:0] prev_diff;
    logic       prev_bout;

    nibble_serial_sub8 #(.WIDTH(8), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .diff  (diff),
        .b_out (b_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; b_in = 1'b0;
        #2;
        checks++;
        if ({diff, b_out, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset: diff=%h b_out=%b busy=%b done=%b, want all 0", diff, b_out, busy, done);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        prev_diff = 8'h00; prev_bout = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input logic [7:0] ed, input logic eb, input string nm);
        @(negedge clk);
        a = av; b = bv; b_in = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hA5; b = 8'h5A; b_in = ~bi;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b diff=%h, want 1 0 %h", nm, busy, done, diff, prev_diff);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || b_out !== prev_bout) begin
            errors++;
            $display("FAIL %s run: busy=%b done=%b diff=%h b_out=%b, want 1 0 %h %b", nm, busy, done, diff, b_out, prev_diff, prev_bout);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || b_out !== eb) begin
            errors++;
            $display("FAIL %s result: done=%b busy=%b diff=%h b_out=%b, want 1 0 %h %b", nm, done, busy, diff, b_out, ed, eb);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || diff !== ed || b_out !== eb) begin
            errors++;
            $display("FAIL %s hold: done=%b diff=%h b_out=%b, want 0 %h %b", nm, done, diff, b_out, ed, eb);
        end
        prev_diff = ed; prev_bout = eb;
    endtask

    task automatic test_basic();
        run_op(8'h63, 8'h1A, 1'b0, 8'h49, 1'b0, "basic");
    endtask

    task automatic test_borrow();
        run_op(8'h1A, 8'h63, 1'b0, 8'hB7, 1'b1, "borrow1");
        run_op(8'h0B, 8'h7B, 1'b1, 8'h8F, 1'b1, "borrow2");
    endtask

    task automatic test_extreme();
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "extreme1");
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "extreme2");
    endtask

    task automatic test_start_while_busy();
        int ndone;
        @(negedge clk);
        a = 8'h69; b = 8'h30; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || diff !== 8'h39 || b_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_start result: done=%b diff=%h b_out=%b, want 1 39 0", done, diff, b_out);
        end
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || diff !== 8'h39) begin
            errors++;
            $display("FAIL busy_start dropped: activity cycles=%0d diff=%h, want 0 39", ndone, diff);
        end
        prev_diff = 8'h39; prev_bout = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        logic       oi [3];
        logic [7:0] ed [3];
        logic       eb [3];
        oa[0] = 8'h10; ob[0] = 8'h01; oi[0] = 1'b0; ed[0] = 8'h0F; eb[0] = 1'b0;
        oa[1] = 8'h05; ob[1] = 8'h09; oi[1] = 1'b1; ed[1] = 8'hFB; eb[1] = 1'b1;
        oa[2] = 8'hC8; ob[2] = 8'h37; oi[2] = 1'b1; ed[2] = 8'h90; eb[2] = 1'b0;
        @(negedge clk);
        a = oa[0]; b = ob[0]; b_in = oi[0]; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff) begin
                errors++;
                $display("FAIL b2b accept%0d: busy=%b done=%b diff=%h, want 1 0 %h", i, busy, done, diff, prev_diff);
            end
            if (i < 2) begin
                a = oa[i+1]; b = ob[i+1]; b_in = oi[i+1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff) begin
                errors++;
                $display("FAIL b2b run%0d: busy=%b done=%b diff=%h, want 1 0 %h", i, busy, done, diff, prev_diff);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || diff !== ed[i] || b_out !== eb[i]) begin
                errors++;
                $display("FAIL b2b result%0d: done=%b busy=%b diff=%h b_out=%b, want 1 0 %h %b", i, done, busy, diff, b_out, ed[i], eb[i]);
            end
            prev_diff = ed[i]; prev_bout = eb[i];
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        @(negedge clk);
        a = 8'h63; b = 8'h1A; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({diff, b_out, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: diff=%h b_out=%b busy=%b done=%b, want all 0", diff, b_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1 || diff !== 8'h00) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset quiet: bad cycles=%0d, want 0", ndone);
        end
        prev_diff = 8'h00; prev_bout = 1'b0;
        run_op(8'h69, 8'h30, 1'b1, 8'h38, 1'b0, "post_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_extreme();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub8.md
Name: nibble_serial_sub8

Overview:
- Multi-cycle subtractor computing diff = a - b - b_in.
- Companion to the adder datapath: it reuses one SLICE-bit add slice over several cycles instead of a full-width combinational chain.
- Operands are taken in with a start/busy/done handshake.
- The result and borrow-out are held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; passes per operation = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  minuend, sampled at the accept edge
- b  input  WIDTH  subtrahend, sampled at the accept edge
- b_in  input  1  borrow in, sampled at the accept edge
- diff  output  WIDTH  result (a - b - b_in) mod 2^WIDTH
- b_out  output  1  borrow out; 1 when a < b + b_in (unsigned)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/b_out update

Behaviour:
- Reset: on rst_n=0, asynchronously, regardless of clk, set:
  - diff=0, b_out=0, busy=0, done=0;
  - state=IDLE, slice counter=0;
  - internal operand and partial-result registers cleared.
- Reset mid-operation aborts the operation. No done pulse is produced and diff keeps its reset value of 0.
- States: IDLE and RUN.
- IDLE:
  - An edge with start=1 is the accept edge.
  - It latches a, b and b_in.
  - It sets the internal carry register to ~b_in and clears the slice counter k to 0.
  - It asserts busy and moves to RUN.
- RUN: each edge processes slice k, bits [k*SLICE+SLICE-1 : k*SLICE].
  - {c_next, s} = a_k + ~b_k + carry, computed as a (SLICE+1)-bit add.
  - s is written to the partial-result register at slice k.
  - carry <= c_next, then k increments.
- On the edge processing the last slice (k = WIDTH/SLICE-1):
  - diff <= full partial result, including this slice.
  - b_out <= ~c_next.
  - done <= 1 and busy <= 0; state returns to IDLE.
- Latency: done is high in the cycle following the WIDTH/SLICE-th edge after the accept edge. With defaults that is 2 edges after accept.
- Throughput: one operation every WIDTH/SLICE+1 cycles.
- done is high for exactly one cycle. It is 0 on all other cycles.
- diff and b_out change only on a done edge or on reset. Partial results never appear on the outputs.
- start while busy=1 is ignored. Operands are not resampled, and the in-flight operation is unaffected.
- Back-to-back: start=1 in the cycle where done=1 is accepted, because state is IDLE and busy=0 then. done falls on that same edge.
- start held high continuously: a new operation is accepted on every IDLE edge, with operands resampled each time.
- a, b and b_in may change freely while busy=1; the latched values are used.
- Wrap-around: diff is always mod 2^WIDTH. b_out is the only indication of underflow.
- No overflow or sign handling; the block is unsigned only.

Test Plan:
- Basic subtraction: rst_n low then high; a=0x63, b=0x1A, b_in=0, start for 1 cycle -> busy high for 2 cycles, then done pulse; diff=0x49, b_out=0.
- Borrow out: a=0x1A, b=0x63, b_in=0 -> diff=0xB7, b_out=1. Also a=0x0B, b=0x7B, b_in=1 -> diff=0x8F, b_out=1.
- Extreme case: a=0x00, b=0xFF, b_in=1 -> diff=0x00, b_out=1. Also a=0xFF, b=0xFF, b_in=0 -> diff=0x00, b_out=0.
- Start while busy: accept a=0x69, b=0x30; one cycle later pulse start with a=0x01, b=0x01 -> single done, diff=0x39, b_out=0, second request dropped.
- Back-to-back with start held high across 3 operations -> done every 3rd cycle. Results match the golden model a-b-b_in on each latched operand set, and diff stays stable between done pulses.
- Reset mid-operation: assert rst_n=0 between clock edges one cycle after accept -> busy, done, diff and b_out go to 0 immediately, with no done after release. The next start then completes normally.
